// File: rtl/enigma_pkg.sv
// -----------------------------------------------------------------------------
// enigma_pkg
// Shared constants and types for the enigma datapath: ASCII codes handled
// specially by the rotor driver, rotor wiring-table geometry, and the
// rotor-driver FSM state type.
// -----------------------------------------------------------------------------
package enigma_pkg;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;
    localparam logic [7:0] ASCII_Q = 8'h3F;

    localparam int unsigned ROTOR_N = 26;
    localparam int unsigned IDX_W   = ROTOR_N * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_HOLD
    } drv_state_t;

    // Only upper-case letters go through the rotor; everything else bypasses.
    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

endpackage

// File: rtl/char_fifo.sv
// -----------------------------------------------------------------------------
// char_fifo
// Small first-word-fall-through character buffer. The head entry is always
// presented on dout straight from the storage flops.
//
// Ports:
//   clk, reset_n  clock / asynchronous active-low reset
//   push, din     write strobe and 8-bit data (ignored while full)
//   pop           remove head entry (ignored while empty)
//   dout          current head entry
//   full, empty   occupancy flags
// -----------------------------------------------------------------------------
module char_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rotor_driver.sv
// -----------------------------------------------------------------------------
// rotor_driver
// Initiator side of the rotor handshake. Buffers an incoming character stream,
// sends upper-case letters one at a time to a rotor stage (r_valid/r_en/r_done)
// and forwards everything else untouched, preserving input order. Results are
// offered downstream on a ready/valid interface. Also registers and strobes
// the rotor configuration.
//
// Ports:
//   clk, reset_n                      clock / asynchronous active-low reset
//   cfg_set, cfg_offset, cfg_delay,
//   cfg_idx, cfg_dec                  configuration request and values
//   cfg_err                           1-cycle pulse: request rejected (busy)
//   in_valid, in_ready, in_char       upstream character stream
//   out_valid, out_ready, out_char    downstream result stream
//   r_set, r_offset, r_delay,
//   r_idx, r_dec                      registered configuration to the rotor
//   r_valid, r_din, r_en              character strobe / data / step enable
//   r_done, r_dout                    rotor result
//   timeout_err                       sticky rotor-timeout flag
// -----------------------------------------------------------------------------
module rotor_driver
    import enigma_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cfg_set,
    input  logic [31:0]    cfg_offset,
    input  logic [31:0]    cfg_delay,
    input  logic [207:0]   cfg_idx,
    input  logic           cfg_dec,
    output logic           cfg_err,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_char,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_char,
    output logic           r_set,
    output logic [31:0]    r_offset,
    output logic [31:0]    r_delay,
    output logic [207:0]   r_idx,
    output logic           r_dec,
    output logic           r_valid,
    output logic [7:0]     r_din,
    output logic           r_en,
    input  logic           r_done,
    input  logic [7:0]     r_dout,
    output logic           timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    drv_state_t       state;
    drv_state_t       state_next;

    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    logic             in_open;
    logic [CNT_W-1:0] wait_cnt;
    logic             cfg_accept;
    logic             dispatch;
    logic             bypass;
    logic             done_seen;
    logic             timed_out;

    // in_open keeps in_ready low while in reset, so every output reads 0 then.
    assign in_ready   = in_open & ~fifo_full;
    assign fifo_push  = in_valid & in_ready;
    assign cfg_accept = cfg_set && (state == ST_IDLE) && fifo_empty && !out_valid;

    assign r_valid = (state == ST_ISSUE);
    assign r_en    = (state == ST_WAIT);

    char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (in_char),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        dispatch   = 1'b0;
        bypass     = 1'b0;
        done_seen  = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !out_valid) begin
                    fifo_pop = 1'b1;
                    if (is_upper(fifo_dout)) begin
                        dispatch   = 1'b1;
                        state_next = ST_ISSUE;
                    end else begin
                        bypass = 1'b1;
                    end
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the last allowed cycle still wins.
                if (r_done) begin
                    done_seen  = 1'b1;
                    state_next = ST_DONE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_open     <= 1'b0;
            cfg_err     <= 1'b0;
            r_set       <= 1'b0;
            r_offset    <= '0;
            r_delay     <= '0;
            r_idx       <= '0;
            r_dec       <= 1'b0;
            r_din       <= '0;
            wait_cnt    <= '0;
            out_char    <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            in_open <= 1'b1;
            r_set   <= cfg_accept;
            cfg_err <= cfg_set & ~cfg_accept;

            if (cfg_accept) begin
                r_offset    <= cfg_offset;
                r_delay     <= cfg_delay;
                r_idx       <= cfg_idx;
                r_dec       <= cfg_dec;
                timeout_err <= 1'b0;
            end

            if (dispatch) begin
                r_din <= fifo_dout;
            end

            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (done_seen) begin
                out_char <= r_dout;
            end else if (timed_out) begin
                out_char    <= ASCII_Q;
                timeout_err <= 1'b1;
            end else if (bypass) begin
                out_char <= fifo_dout;
            end

            // out_valid rises on leaving DONE so the result is offered only
            // from HOLD, where it is held until the downstream handshake.
            if (bypass || (state == ST_DONE)) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rotor_driver.sv
module tb_rotor_driver;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cfg_set;
    logic [31:0]  cfg_offset;
    logic [31:0]  cfg_delay;
    logic [207:0] cfg_idx;
    logic         cfg_dec;
    logic         cfg_err;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_char;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_char;
    logic         r_set;
    logic [31:0]  r_offset;
    logic [31:0]  r_delay;
    logic [207:0] r_idx;
    logic         r_dec;
    logic         r_valid;
    logic [7:0]   r_din;
    logic         r_en;
    logic         r_done;
    logic [7:0]   r_dout;
    logic         timeout_err;

    int n_asserts = 0;
    int n_fail    = 0;

    rotor_driver #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_set     (cfg_set),
        .cfg_offset  (cfg_offset),
        .cfg_delay   (cfg_delay),
        .cfg_idx     (cfg_idx),
        .cfg_dec     (cfg_dec),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_char    (out_char),
        .r_set       (r_set),
        .r_offset    (r_offset),
        .r_delay     (r_delay),
        .r_idx       (r_idx),
        .r_dec       (r_dec),
        .r_valid     (r_valid),
        .r_din       (r_din),
        .r_en        (r_en),
        .r_done      (r_done),
        .r_dout      (r_dout),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Rotor model: answers with r_din+1 during the second enabled cycle.
    logic rot_on;
    int   en_seen;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)  en_seen <= 0;
        else if (r_en) en_seen <= en_seen + 1;
        else           en_seen <= 0;
    end
    assign r_done = rot_on && r_en && (en_seen == 1);
    assign r_dout = r_din + 8'd1;

    // Free-running event counters and downstream log.
    int         rvalid_cnt = 0;
    int         ren_cnt    = 0;
    int         rset_cnt   = 0;
    logic [7:0] out_log[$];
    always @(posedge clk) begin
        if (r_valid) rvalid_cnt++;
        if (r_en)    ren_cnt++;
        if (r_set)   rset_cnt++;
        if (out_valid && out_ready) out_log.push_back(out_char);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [207:0] ident;
        logic [7:0]   str6 [6];
        int           base_rv, base_en, base_rs, base_log, lat, idx;
        logic         acc;

        for (int k = 0; k < 26; k++) ident[207 - 8*k -: 8] = 8'(k);
        str6 = '{8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};

        reset_n = 1'b0; cfg_set = 1'b0; cfg_offset = '0; cfg_delay = '0;
        cfg_idx = '0; cfg_dec = 1'b0; in_valid = 1'b0; in_char = '0;
        out_ready = 1'b0; rot_on = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_r_en", 32'(r_en), 0);
        chk("rst_r_offset", r_offset, 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        reset_n = 1'b1;
        tick(); tick();
        chk("in_ready_after_rst", 32'(in_ready), 1);

        // Configuration accepted
        base_rs = rset_cnt;
        cfg_set = 1'b1; cfg_offset = 1; cfg_delay = 3; cfg_idx = ident; cfg_dec = 1'b0;
        tick();
        cfg_set = 1'b0;
        chk("cfg_r_set", 32'(r_set), 1);
        chk("cfg_r_offset", r_offset, 1);
        chk("cfg_r_delay", r_delay, 3);
        chk("cfg_r_idx", 32'(r_idx === ident), 1);
        chk("cfg_err_ok", 32'(cfg_err), 0);
        tick();
        chk("cfg_r_set_pulse", 32'(rset_cnt - base_rs), 1);

        // Single letter through the rotor
        base_rv = rvalid_cnt; base_en = ren_cnt;
        in_valid = 1'b1; in_char = 8'h41;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk("A_latency", 32'(lat), 5);
        chk("A_out_char", 32'(out_char), 32'h42);
        chk("A_r_din", 32'(r_din), 32'h41);
        chk("A_r_valid_cycles", 32'(rvalid_cnt - base_rv), 1);
        chk("A_r_en_cycles", 32'(ren_cnt - base_en), 2);
        tick(); tick(); tick();
        chk("A_hold_valid", 32'(out_valid), 1);
        chk("A_hold_char", 32'(out_char), 32'h42);
        out_ready = 1'b1;
        tick();
        chk("A_released", 32'(out_valid), 0);

        // "A B" with a bypassed space, order preserved
        base_log = out_log.size(); base_rv = rvalid_cnt;
        in_valid = 1'b1;
        in_char = 8'h41; tick();
        in_char = 8'h20; tick();
        in_char = 8'h42; tick();
        in_valid = 1'b0;
        for (int t = 0; t < 60 && out_log.size() < base_log + 3; t++) tick();
        chk("AB_count", 32'(out_log.size() - base_log), 3);
        if (out_log.size() >= base_log + 3) begin
            chk("AB_0", 32'(out_log[base_log]), 32'h42);
            chk("AB_1_bypass", 32'(out_log[base_log + 1]), 32'h20);
            chk("AB_2", 32'(out_log[base_log + 2]), 32'h43);
        end
        chk("AB_r_valid_cycles", 32'(rvalid_cnt - base_rv), 2);
        chk("AB_r_din_held", 32'(r_din), 32'h42);

        // Backpressure: one char in flight + 4 buffered, 6th stalls
        out_ready = 1'b0;
        base_log = out_log.size();
        idx = 0;
        for (int t = 0; t < 8; t++) begin
            in_valid = 1'b1; in_char = str6[idx];
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 5);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_head_out", 32'(out_char), 32'h44);
        out_ready = 1'b1;
        for (int t = 0; t < 20 && idx < 6; t++) begin
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_6th_accepted", 32'(idx), 6);
        for (int t = 0; t < 100 && out_log.size() < base_log + 6; t++) tick();
        chk("bp_count", 32'(out_log.size() - base_log), 6);
        if (out_log.size() >= base_log + 6) begin
            for (int k = 0; k < 6; k++)
                chk("bp_order", 32'(out_log[base_log + k]), 32'(str6[k] + 8'd1));
        end

        // Timeout
        out_ready = 1'b0; rot_on = 1'b0; base_en = ren_cnt;
        in_valid = 1'b1; in_char = 8'h5A;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        chk("to_latency", 32'(lat), 19);
        chk("to_out_char", 32'(out_char), 32'h3F);
        chk("to_flag", 32'(timeout_err), 1);
        chk("to_r_en_cycles", 32'(ren_cnt - base_en), 16);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tick();
        chk("to_sticky", 32'(timeout_err), 1);
        cfg_set = 1'b1; cfg_offset = 2;
        tick();
        cfg_set = 1'b0;
        chk("to_cleared", 32'(timeout_err), 0);
        chk("to_cfg_offset", r_offset, 2);

        // cfg_set while busy in WAIT is rejected
        in_valid = 1'b1; in_char = 8'h4B;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("busy_in_wait", 32'(r_en), 1);
        base_rs = rset_cnt;
        cfg_set = 1'b1; cfg_offset = 7;
        tick();
        cfg_set = 1'b0;
        chk("busy_cfg_err", 32'(cfg_err), 1);
        chk("busy_r_set", 32'(r_set), 0);
        chk("busy_r_offset", r_offset, 2);
        tick();
        chk("busy_cfg_err_pulse", 32'(cfg_err), 0);
        chk("busy_no_r_set", 32'(rset_cnt - base_rs), 0);

        // Reset during WAIT with more characters queued
        in_valid = 1'b1; in_char = 8'h4C; tick();
        in_char = 8'h4D; tick();
        in_valid = 1'b0;
        chk("rst2_in_wait", 32'(r_en), 1);
        reset_n = 1'b0;
        #1;
        chk("rst2_r_en", 32'(r_en), 0);
        chk("rst2_out_valid", 32'(out_valid), 0);
        chk("rst2_in_ready", 32'(in_ready), 0);
        chk("rst2_r_din", 32'(r_din), 0);
        chk("rst2_r_offset", r_offset, 0);
        tick();
        reset_n = 1'b1;
        rot_on = 1'b1; out_ready = 1'b1;
        base_log = out_log.size(); base_rv = rvalid_cnt;
        for (int t = 0; t < 30; t++) tick();
        chk("rst2_no_output", 32'(out_log.size() - base_log), 0);
        chk("rst2_no_issue", 32'(rvalid_cnt - base_rv), 0);
        chk("rst2_fifo_empty_ready", 32'(in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
